// File: rtl/clk_div_bank.sv
// clk_div_bank: multi-channel programmable clock divider, single clock domain.
//
// Each channel divides clk by 2*(H+1), where H is a per-channel half-period
// count. It drives a registered square wave (clk_out) and a one-cycle strobe
// (tick) that is high in the cycle clk_out has just gone 0->1. A new H is
// written through a valid/ready port and parked as "pending" until the
// channel's next half-period boundary, so the output never glitches.
//
// Ports:
//   clk        system clock, all logic on the rising edge
//   reset      synchronous, active-high reset
//   en         per-channel run enable
//   cfg_valid  divisor write request
//   cfg_ch     target channel of the write (codes >= NUM_CH are discarded)
//   cfg_div    new half-period minus one (H)
//   cfg_ready  write accepted when cfg_valid && cfg_ready
//   clk_out    divided square waves, registered
//   tick       rising-edge strobes, registered
//   and_mask   channels included in and_out
//   and_out    registered AND of the masked clk_out bits (0 if mask is empty)

// ---------------------------------------------------------------------------
// clk_div_ch: one divider channel.
//   en_i      run enable
//   wr_i      accepted write for this channel (only ever high when !pend_o)
//   wr_div_i  value to park as pending H
//   pend_o    a written H is waiting for its apply cycle
//   clk_o     divided output
//   tick_o    strobe in the cycle clk_o has just become 1
// ---------------------------------------------------------------------------
module clk_div_ch #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en_i,
  input  logic             wr_i,
  input  logic [CNT_W-1:0] wr_div_i,
  output logic             pend_o,
  output logic             clk_o,
  output logic             tick_o
);

  logic [CNT_W-1:0] cnt_q,  cnt_d;
  logic [CNT_W-1:0] h_q,    h_d;
  logic [CNT_W-1:0] pval_q, pval_d;
  logic             pend_q, pend_d;
  logic             clk_q,  clk_d;
  logic             tick_q, tick_d;

  always_comb begin
    cnt_d  = cnt_q;
    h_d    = h_q;
    pval_d = pval_q;
    pend_d = pend_q;
    clk_d  = clk_q;
    tick_d = 1'b0;

    if (en_i) begin
      // >= rather than == so a count left above H can never run away.
      if (cnt_q >= h_q) begin
        cnt_d  = '0;
        clk_d  = ~clk_q;
        tick_d = ~clk_q;
        // Half-period boundary: the only safe point to swap H while running.
        if (pend_q) begin
          h_d    = pval_q;
          pend_d = 1'b0;
        end
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else if (pend_q) begin
      // Output is frozen, so apply at once and restart the half-period.
      h_d    = pval_q;
      cnt_d  = '0;
      pend_d = 1'b0;
    end

    // Never collides with the apply above: a write is only accepted while
    // pend_q is clear, and applying requires pend_q set.
    if (wr_i) begin
      pend_d = 1'b1;
      pval_d = wr_div_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      h_q    <= '0;
      pval_q <= '0;
      pend_q <= 1'b0;
      clk_q  <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      h_q    <= h_d;
      pval_q <= pval_d;
      pend_q <= pend_d;
      clk_q  <= clk_d;
      tick_q <= tick_d;
    end
  end

  assign pend_o = pend_q;
  assign clk_o  = clk_q;
  assign tick_o = tick_q;

endmodule

// ---------------------------------------------------------------------------
// clk_div_bank: top level, NUM_CH channels plus config decode and and_out.
// ---------------------------------------------------------------------------
module clk_div_bank #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 8,
  parameter int CH_W   = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] en,
  input  logic              cfg_valid,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  output logic              cfg_ready,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick,
  input  logic [NUM_CH-1:0] and_mask,
  output logic              and_out
);

  typedef struct packed {
    logic [CH_W-1:0]  ch;
    logic [CNT_W-1:0] div;
  } cfg_req_t;

  cfg_req_t          req;
  logic [NUM_CH-1:0] pend;
  logic [NUM_CH-1:0] wr;
  logic              sel_pend;
  logic              and_q, and_d;

  assign req = '{ch: cfg_ch, div: cfg_div};

  // Pending flag of the addressed channel; an out-of-range code matches no
  // channel and so reads as "not pending", keeping cfg_ready high for it.
  always_comb begin
    sel_pend = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (req.ch == CH_W'(i)) sel_pend = pend[i];
    end
  end

  // Depends only on reset, cfg_ch and pend -- never on cfg_valid.
  assign cfg_ready = ~reset & ~sel_pend;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign wr[g] = cfg_valid & cfg_ready & (req.ch == CH_W'(g));

    clk_div_ch #(.CNT_W(CNT_W)) u_ch (
      .clk      (clk),
      .reset    (reset),
      .en_i     (en[g]),
      .wr_i     (wr[g]),
      .wr_div_i (req.div),
      .pend_o   (pend[g]),
      .clk_o    (clk_out[g]),
      .tick_o   (tick[g])
    );
  end

  // Unmasked channels read as 1; an empty mask is forced to 0 rather than
  // the vacuous 1 an AND over nothing would give.
  assign and_d = (|and_mask) & (&(clk_out | ~and_mask));

  always_ff @(posedge clk) begin
    if (reset) and_q <= 1'b0;
    else       and_q <= and_d;
  end

  assign and_out = and_q;

endmodule

// File: tb/tb_clk_div_bank.sv
module tb_clk_div_bank;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 8;
  localparam int CH_W   = 3;

  logic              clk = 1'b0;
  logic              reset;
  logic [NUM_CH-1:0] en;
  logic              cfg_valid;
  logic [CH_W-1:0]   cfg_ch;
  logic [CNT_W-1:0]  cfg_div;
  logic              cfg_ready;
  logic [NUM_CH-1:0] clk_out;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] and_mask;
  logic              and_out;

  int n_chk  = 0;
  int n_pass = 0;

  clk_div_bank #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .CH_W(CH_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .cfg_valid (cfg_valid),
    .cfg_ch    (cfg_ch),
    .cfg_div   (cfg_div),
    .cfg_ready (cfg_ready),
    .clk_out   (clk_out),
    .tick      (tick),
    .and_mask  (and_mask),
    .and_out   (and_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0h want %0h", tag, act, exp);
    else n_pass++;
  endtask

  // Advance one edge; registered outputs are then stable and inputs can change.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; en = '0; cfg_valid = 1'b0; cfg_ch = '0; cfg_div = '0; and_mask = '0;
    step();
    reset = 1'b0;
    #1;
  endtask

  initial begin
    // ---------------- 1: reset state, free-running divide-by-2 ----------------
    reset = 1'b1; en = '0; cfg_valid = 1'b0; cfg_ch = '0; cfg_div = '0; and_mask = '0;
    step();
    chk("rst_clk_out", 32'(clk_out), 32'h0);
    chk("rst_tick", 32'(tick), 32'h0);
    chk("rst_and_out", 32'(and_out), 32'h0);
    chk("rst_cfg_ready", 32'(cfg_ready), 32'h0);
    reset = 1'b0; en = 4'hF;
    #1;
    chk("t1_cfg_ready", 32'(cfg_ready), 32'h1);
    for (int e = 1; e <= 4; e++) begin
      step();
      chk($sformatf("t1_clk_out_e%0d", e), 32'(clk_out), (e % 2) ? 32'hF : 32'h0);
      chk($sformatf("t1_tick_e%0d", e), 32'(tick), (e % 2) ? 32'hF : 32'h0);
    end

    // ---------------- 2: ch1 H=3 -> period 8, others untouched ----------------
    do_reset();
    en = 4'hF; cfg_valid = 1'b1; cfg_ch = 3'd1; cfg_div = 8'd3;
    #1;
    chk("t2_ready_pre", 32'(cfg_ready), 32'h1);
    step();                                   // edge1: accepted
    cfg_valid = 1'b0;
    #1;
    chk("t2_ready_pend", 32'(cfg_ready), 32'h0);
    cfg_ch = 3'd2;
    #1;
    chk("t2_ready_other_ch", 32'(cfg_ready), 32'h1);
    cfg_ch = 3'd1;
    for (int e = 2; e <= 14; e++) begin
      logic [3:0] eo, et;
      logic hi, tk;
      step();
      hi = (e >= 6 && e <= 9) || e == 14;
      tk = (e == 6) || (e == 14);
      eo = (e % 2) ? 4'hF : 4'h0;
      et = eo;
      eo[1] = hi;
      et[1] = tk;
      chk($sformatf("t2_clk_out_e%0d", e), 32'(clk_out), 32'(eo));
      chk($sformatf("t2_tick_e%0d", e), 32'(tick), 32'(et));
      if (e == 2) chk("t2_ready_after_apply", 32'(cfg_ready), 32'h1);
    end

    // ---------------- 3: back-to-back writes to ch2 stall ----------------
    do_reset();
    en = 4'b0100; cfg_valid = 1'b1; cfg_ch = 3'd2; cfg_div = 8'd9;
    step();                                   // edge1: accept H=9
    cfg_valid = 1'b0;
    step();                                   // edge2: apply H=9, clk_out[2]=0
    cfg_valid = 1'b1; cfg_div = 8'd5;
    step();                                   // edge3: accept 5
    cfg_div = 8'd2;
    #1;
    chk("t3_stall_e3", 32'(cfg_ready), 32'h0);
    for (int e = 4; e <= 11; e++) begin
      step();
      chk($sformatf("t3_stall_e%0d", e), 32'(cfg_ready), 32'h0);
      chk($sformatf("t3_low_e%0d", e), 32'(clk_out[2]), 32'h0);
    end
    step();                                   // edge12: apply 5, toggle high
    chk("t3_e12_clk", 32'(clk_out[2]), 32'h1);
    chk("t3_e12_tick", 32'(tick[2]), 32'h1);
    chk("t3_e12_ready", 32'(cfg_ready), 32'h1);
    step();                                   // edge13: accept 2
    cfg_valid = 1'b0;
    #1;
    chk("t3_e13_ready", 32'(cfg_ready), 32'h0);
    for (int e = 14; e <= 27; e++) begin
      logic hi, tk;
      step();
      hi = (e <= 17) || (e >= 21 && e <= 23) || e == 27;
      tk = (e == 21) || (e == 27);
      chk($sformatf("t3_clk_e%0d", e), 32'(clk_out[2]), 32'(hi));
      chk($sformatf("t3_tick_e%0d", e), 32'(tick[2]), 32'(tk));
    end

    // ---------------- 4: enable gating and write while disabled ----------------
    do_reset();
    en = 4'b0001; cfg_valid = 1'b1; cfg_ch = 3'd0; cfg_div = 8'd4;
    step();                                   // edge1
    cfg_valid = 1'b0;
    step(); step(); step();                   // edges2..4: low, cnt=2
    en = 4'b0000;
    for (int e = 5; e <= 11; e++) begin
      step();
      chk($sformatf("t4_frz_clk_e%0d", e), 32'(clk_out[0]), 32'h0);
      chk($sformatf("t4_frz_tick_e%0d", e), 32'(tick[0]), 32'h0);
    end
    en = 4'b0001;
    for (int e = 12; e <= 15; e++) begin
      step();
      chk($sformatf("t4_resume_clk_e%0d", e), 32'(clk_out[0]), (e >= 14) ? 32'h1 : 32'h0);
      chk($sformatf("t4_resume_tick_e%0d", e), 32'(tick[0]), (e == 14) ? 32'h1 : 32'h0);
    end
    en = 4'b0000; cfg_valid = 1'b1; cfg_div = 8'd1;
    step();                                   // edge16: accept H=1 while disabled
    cfg_valid = 1'b0;
    step();                                   // edge17: apply, cnt=0
    chk("t4_dis_apply_ready", 32'(cfg_ready), 32'h1);
    chk("t4_dis_hold_clk", 32'(clk_out[0]), 32'h1);
    en = 4'b0001;
    for (int e = 18; e <= 21; e++) begin
      step();
      chk($sformatf("t4_newh_clk_e%0d", e), 32'(clk_out[0]), (e == 19 || e == 20) ? 32'h0 : 32'h1);
      chk($sformatf("t4_newh_tick_e%0d", e), 32'(tick[0]), (e == 21) ? 32'h1 : 32'h0);
    end

    // ---------------- 5: masked AND and out-of-range channel ----------------
    do_reset();
    en = 4'b0101; and_mask = 4'b0101; cfg_valid = 1'b1; cfg_ch = 3'd2; cfg_div = 8'd3;
    for (int e = 1; e <= 13; e++) begin
      step();
      if (e == 1) cfg_valid = 1'b0;
      chk($sformatf("t5_and_e%0d", e), 32'(and_out), (e == 2 || e == 8 || e == 10) ? 32'h1 : 32'h0);
    end
    and_mask = 4'b0000;
    for (int e = 14; e <= 17; e++) begin
      step();
      chk($sformatf("t5_and_nomask_e%0d", e), 32'(and_out), 32'h0);
    end
    cfg_valid = 1'b1; cfg_ch = 3'd7; cfg_div = 8'd9;
    #1;
    chk("t5_ch7_ready", 32'(cfg_ready), 32'h1);
    step();
    cfg_valid = 1'b0;
    #1;
    chk("t5_ch7_ready_after", 32'(cfg_ready), 32'h1);
    cfg_ch = 3'd3;
    #1;
    chk("t5_ch7_no_alias", 32'(cfg_ready), 32'h1);

    // ---------------- 6: reset with a pending write ----------------
    do_reset();
    en = 4'hF; and_mask = 4'hF; cfg_valid = 1'b1; cfg_ch = 3'd1; cfg_div = 8'd5;
    step();                                   // edge1: all high, ch1 pending
    cfg_valid = 1'b0;
    chk("t6_pre_clk_out", 32'(clk_out), 32'hF);
    reset = 1'b1;
    #1;
    chk("t6_ready_in_reset", 32'(cfg_ready), 32'h0);
    step();                                   // edge2: reset
    chk("t6_rst_clk_out", 32'(clk_out), 32'h0);
    chk("t6_rst_tick", 32'(tick), 32'h0);
    chk("t6_rst_and_out", 32'(and_out), 32'h0);
    reset = 1'b0;
    #1;
    chk("t6_ready_ch1", 32'(cfg_ready), 32'h1);
    for (int e = 3; e <= 6; e++) begin
      step();
      chk($sformatf("t6_clk_out_e%0d", e), 32'(clk_out), (e % 2) ? 32'hF : 32'h0);
      chk($sformatf("t6_tick_e%0d", e), 32'(tick), (e % 2) ? 32'hF : 32'h0);
      if (e >= 4) chk($sformatf("t6_and_e%0d", e), 32'(and_out), (e % 2) ? 32'h0 : 32'h1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/clk_div_bank.md
Name: clk_div_bank

Overview:
Multi-channel programmable clock divider for the tile. All logic runs in a single clock domain. Each channel produces a divided square wave plus a one-cycle rising-edge strobe, with a divide ratio that can be changed at runtime. Ratio changes take effect glitch-free at the next half-period boundary. A maskable registered AND of the channel outputs generalises the fixed combined output of the earlier divider.

Parameters:
NUM_CH, 4, number of divider channels (1..16)
CNT_W, 8, width of half-period count and divisor field
CH_W, 2, width of channel select; must satisfy 2^CH_W >= NUM_CH

Ports:
clk  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
en  input  NUM_CH  per-channel run enable
cfg_valid  input  1  divisor write request
cfg_ch  input  CH_W  target channel of write
cfg_div  input  CNT_W  half-period minus 1 (H); output period = 2*(H+1) clk cycles
cfg_ready  output  1  write accepted when cfg_valid && cfg_ready
clk_out  output  NUM_CH  divided square waves, registered
tick  output  NUM_CH  one-cycle pulse coincident with clk_out[i] going 0->1
and_mask  input  NUM_CH  channels included in and_out
and_out  output  1  registered AND of masked clk_out bits

Behaviour:
- One clock; reset is synchronous and active-high. Ports are named clk and reset.
- Reset state, taking effect on the first clk edge with reset=1:
  - Outputs: clk_out=0, tick=0, and_out=0.
  - Per channel: cnt=0, H=0 (divide-by-2 default), pend=0, pend_val=0.
  - cfg_ready=0 while reset is high.
- Per channel i, when en[i]=1, each cycle:
  - If cnt >= H: cnt<=0 and clk_out[i] toggles. If pend is set, H<=pend_val and pend<=0; the new H governs the following half-period.
  - Otherwise cnt<=cnt+1.
  - The >= compare guards against cnt>H.
- Per channel i, when en[i]=0:
  - cnt and clk_out[i] hold; tick[i]=0.
  - If pend is set, then H<=pend_val, cnt<=0, pend<=0 on that cycle.
  - On re-enable, counting resumes from the held state.
- tick[i] is registered: it is 1 exactly in the cycles where clk_out[i] has just become 1. For H=0 that is every other cycle.
- Config handshake:
  - cfg_ready = !reset && !(cfg_ch < NUM_CH && pend[cfg_ch]).
  - On accept with cfg_ch < NUM_CH: pend_val[cfg_ch]<=cfg_div and pend[cfg_ch]<=1.
  - On accept with cfg_ch >= NUM_CH: cfg_ready stays 1; the write is discarded with no effect.
  - At most one pending value per channel. A second write to that channel stalls (cfg_ready=0) until the apply cycle completes; it can be accepted the cycle after pend clears.
  - A write to a different channel is never blocked by another channel's pend.
  - cfg_ready is combinational from cfg_ch, pend and reset; no combinational path from cfg_valid.
- Apply latency: the earliest change in clk_out timing is the cycle after acceptance, if that cycle is a terminal count. The maximum is H_old+1 cycles after acceptance.
- and_out is registered each cycle as AND over i of (clk_out[i] | !and_mask[i]), computed on current registered clk_out. It therefore lags clk_out by one cycle. If and_mask==0, and_out=0.
- Width rules:
  - cnt is CNT_W bits and never exceeds H.
  - H=2^CNT_W-1 gives the maximum period, 2^(CNT_W+1) cycles.
- Reset mid-operation discards pending writes and an in-progress handshake. The handshake is not retried.

Test Plan:
1. Reset, then en=4'b1111, no cfg -> every clk_out toggles each cycle (period 2); tick[i] high every 2nd cycle; cfg_ready=1.
2. Write ch1 cfg_div=3 while H=0 -> accepted in 1 cycle; from the next toggle, clk_out[1] is 4 high / 4 low (period 8); tick[1] every 8 cycles; other channels are unaffected.
3. Set ch2 H=9, then back-to-back writes to ch2 (5 then 2) -> second held with cfg_ready=0 for up to 10 cycles. It is accepted the cycle after the first applies, and the final period is 6.
4. ch0 H=4 running; drop en[0] for 7 cycles mid half-period -> clk_out[0] and cnt frozen, tick[0]=0. On re-enable, the remaining count completes with no extra or lost edge. A write during disable applies next cycle with cnt reset to 0.
5. ch0 H=0, ch2 H=3, and_mask=4'b0101 -> and_out = registered AND of clk_out[0]&clk_out[2], one cycle late. With and_mask=0, and_out stays 0. cfg_ch=3'd7 (CH_W=3, NUM_CH=4) is accepted and has no effect.
6. Assert reset for 1 cycle with a pending write and outputs high -> next cycle all outputs 0, H=0, pend cleared, and the pending value is never applied.
